axis_pha_acq_controller: RTL

Acquisition sequencer for the pulse height analyzer. It gates the ADC sample stream into the analyzer and the event stream out of it, and holds the analyzer in reset outside acquisition. It counts live time (accepted samples) and accepted events, and ends the run on a time or event limit or on software stop. It sits between the ADC stream source and the analyzer, and between the analyzer and the histogram writer.

---
 rtl/axis_pha_acq_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/axis_pha_acq_controller.sv
// Acquisition sequencer for the pulse height analyzer: gates the sample
// and event streams, counts live time and events, stops on limits.
module axis_pha_acq_controller #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int TIME_WIDTH       = 64,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        ctrl_start,
  input  logic                        ctrl_stop,
  input  logic                        ctrl_clear,
  input  logic [TIME_WIDTH-1:0]       cfg_time_limit,
  input  logic [CNTR_WIDTH-1:0]       cfg_event_limit,
  output logic [1:0]                  sts_state,
  output logic [TIME_WIDTH-1:0]       sts_live_time,
  output logic [CNTR_WIDTH-1:0]       sts_events,
  output logic                        pha_aresetn,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        s_evt_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_evt_tdata,
  input  logic                        s_evt_tvalid,
  input  logic                        m_evt_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_evt_tdata,
  output logic                        m_evt_tvalid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [TIME_WIDTH-1:0]   live_q, live_d, live_inc;
  logic [CNTR_WIDTH-1:0]   evt_q, evt_d, evt_inc;
  logic                    pha_q, pha_d;
  logic                    run;
  logic                    s_fire, e_fire;
  logic                    time_hit, evt_hit;

  assign run = (state_q == S_RUN);

  // Sample gate: pass-through in RUN, drain (drop) otherwise
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = run & s_axis_tvalid;
  assign s_axis_tready = run ? m_axis_tready : 1'b1;

  // Event gate: same rules, late analyzer events are dropped
  assign m_evt_tdata   = s_evt_tdata;
  assign m_evt_tvalid  = run & s_evt_tvalid;
  assign s_evt_tready  = run ? m_evt_tready : 1'b1;

  assign s_fire = run & s_axis_tvalid & m_axis_tready;
  assign e_fire = run & s_evt_tvalid & m_evt_tready;

  assign live_inc = (&live_q) ? live_q : live_q + TIME_WIDTH'(1);
  assign evt_inc  = (&evt_q) ? evt_q : evt_q + CNTR_WIDTH'(1);

  // Limits compared live, so a lowered limit ends the run on the next transfer
  assign time_hit = s_fire && (cfg_time_limit != '0)
                  && (live_inc >= cfg_time_limit);
  assign evt_hit  = e_fire && (cfg_event_limit != '0)
                  && (evt_inc >= cfg_event_limit);

  // Next-state logic; clear beats limit beats stop beats start
  always_comb begin
    state_d = state_q;
    if (ctrl_clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (ctrl_start) state_d = S_RUN;
        S_RUN: begin
          if (time_hit || evt_hit) state_d = S_DONE;
          else if (ctrl_stop)      state_d = S_IDLE;
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Saturating counters of accepted transfers
  always_comb begin
    live_d = live_q;
    evt_d  = evt_q;
    if (ctrl_clear) begin
      live_d = '0;
      evt_d  = '0;
    end else begin
      if (s_fire) live_d = live_inc;
      if (e_fire) evt_d  = evt_inc;
    end
  end

  // Analyzer held in reset whenever the next state is not RUN
  assign pha_d = (state_d == S_RUN);

  // State, counter and analyzer-reset registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      live_q  <= '0;
      evt_q   <= '0;
      pha_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      evt_q   <= evt_d;
      pha_q   <= pha_d;
    end
  end

  assign sts_state     = state_q;
  assign sts_live_time = live_q;
  assign sts_events    = evt_q;
  assign pha_aresetn   = pha_q;

endmodule
